// File: rtl/data_mem_if.sv
// Core data-port request/grant bus between an LSU (master) and a data-memory responder (slave).
// Handshake: the master raises req with addr/ren/wen/wdata/beat and holds all of them
// stable until it sees grnt high; grnt marks the cycle the command is sampled. One
// cycle later the responder pulses rvalid (read data in rdata) or err (access rejected).
interface data_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEAT_SIZE  = 8
);
    localparam int LANES = DATA_WIDTH / BEAT_SIZE;

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ren;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [LANES-1:0]      beat;
    logic                  grnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, addr, ren, wen, wdata, beat,
        input  grnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, ren, wen, wdata, beat,
        output grnt, rvalid, rdata, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised SRAM with byte-lane writes, programmable wait
// states before grant, and a one-cycle response (rvalid or err) after each grant.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BEAT_SIZE   = 8,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus,
    output logic [1:0] dbg_state
);
    localparam int LANES    = DATA_WIDTH / BEAT_SIZE;
    localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = ADDR_WIDTH - OFF_BITS;
    localparam int MEM_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GRANT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ren_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_cmd;
    logic              empty_write;
    logic              access_err;
    logic              take;
    logic              do_write;

    // Access checks are evaluated on the live bus; they only matter in the GRANT cycle.
    assign word_idx     = bus.addr[ADDR_WIDTH-1:OFF_BITS];
    assign mem_idx      = word_idx[MEM_AW-1:0];
    assign misaligned   = |bus.addr[OFF_BITS-1:0];
    assign out_of_range = word_idx >= IDX_W'(DEPTH_WORDS);
    assign bad_cmd      = (bus.ren == bus.wen);
    assign empty_write  = bus.wen & ~|bus.beat;
    assign access_err   = misaligned | out_of_range | bad_cmd | empty_write;
    assign take         = (state_q == S_GRANT) & bus.req;
    assign do_write     = take & ~access_err & bus.wen & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_GRANT;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_M1;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_GRANT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GRANT: state_d = bus.req ? S_RESP : S_IDLE;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reads and writes are mutually exclusive, so reading at the grant edge sees the
    // word exactly as stored at the end of the GRANT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ren_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (take) begin
            ren_q   <= bus.ren;
            err_q   <= access_err;
            rdata_q <= (bus.ren && !access_err) ? mem[mem_idx] : '0;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.beat[i]) begin
                    mem[mem_idx][i*BEAT_SIZE +: BEAT_SIZE] <= bus.wdata[i*BEAT_SIZE +: BEAT_SIZE];
                end
            end
        end
    end

    assign bus.grnt   = (state_q == S_GRANT);
    assign bus.rvalid = (state_q == S_RESP) & ren_q & ~err_q;
    assign bus.err    = (state_q == S_RESP) & err_q;
    assign bus.rdata  = (state_q == S_RESP) ? rdata_q : '0;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with no wait states, one with three,
// both sharing clock and reset.
module tb_data_mem_responder;
    logic       clk;
    logic       rst;
    logic [1:0] st0;
    logic [1:0] st3;

    int tests = 0;
    int fails = 0;

    logic [33:0] exp_q[$];
    logic [31:0] model0[int];
    logic [31:0] model3[int];

    data_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BEAT_SIZE(8)) b0 ();
    data_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BEAT_SIZE(8)) b3 ();

    data_mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave), .dbg_state(st0)
    );
    data_mem_responder #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave), .dbg_state(st3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit sel, input logic q, input logic [31:0] a, input logic r,
                         input logic w, input logic [31:0] d, input logic [3:0] be);
        if (sel) begin
            b3.req = q; b3.addr = a; b3.ren = r; b3.wen = w; b3.wdata = d; b3.beat = be;
        end else begin
            b0.req = q; b0.addr = a; b0.ren = r; b0.wen = w; b0.wdata = d; b0.beat = be;
        end
    endtask

    task automatic sample(input bit sel, output logic g, output logic rv, output logic e,
                          output logic [31:0] rd);
        if (sel) begin
            g = b3.grnt; rv = b3.rvalid; e = b3.err; rd = b3.rdata;
        end else begin
            g = b0.grnt; rv = b0.rvalid; e = b0.err; rd = b0.rdata;
        end
    endtask

    // One access: push the expected response, hold req until grant, check grant cycle
    // and the response one cycle later against the popped expectation.
    task automatic access(input bit sel, input bit start_now, input logic [31:0] a,
                          input logic r, input logic w, input logic [31:0] d,
                          input logic [3:0] be, input bit exp_err, input int exp_g,
                          input string name, output logic [31:0] got);
        logic [33:0] exp;
        logic [31:0] cur;
        logic        sg, srv, se;
        logic [31:0] srd;
        int          idx;
        int          g;
        int          c;
        idx = int'(a >> 2);
        cur = 32'h0;
        if (sel) begin
            if (model3.exists(idx)) cur = model3[idx];
        end else begin
            if (model0.exists(idx)) cur = model0[idx];
        end
        if (!exp_err && w) begin
            for (int i = 0; i < 4; i++) if (be[i]) cur[i*8 +: 8] = d[i*8 +: 8];
            if (sel) model3[idx] = cur; else model0[idx] = cur;
        end
        exp = {exp_err, (r && !exp_err), (r && !exp_err) ? cur : 32'h0};
        exp_q.push_back(exp);
        if (!start_now) begin
            @(posedge clk); #1;
        end
        drive(sel, 1'b1, a, r, w, d, be);
        g = -1;
        c = start_now ? 1 : 0;
        while (g < 0 && c < 40) begin
            @(negedge clk);
            sample(sel, sg, srv, se, srd);
            if (sg) g = c;
            c++;
        end
        tests++;
        if (g !== exp_g) begin
            fails++;
            $display("FAIL %s grant_cycle: got %0d expected %0d", name, g, exp_g);
        end
        got = 32'h0;
        if (g < 0) begin
            drive(sel, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
            exp = exp_q.pop_front();
            return;
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        sample(sel, sg, srv, se, srd);
        exp = exp_q.pop_front();
        tests++;
        if (se !== exp[33]) begin
            fails++;
            $display("FAIL %s err: got %b expected %b", name, se, exp[33]);
        end
        tests++;
        if (srv !== exp[32]) begin
            fails++;
            $display("FAIL %s rvalid: got %b expected %b", name, srv, exp[32]);
        end
        tests++;
        if (srd !== exp[31:0]) begin
            fails++;
            $display("FAIL %s rdata: got %h expected %h", name, srd, exp[31:0]);
        end
        got = srd;
    endtask

    task automatic test_reset();
        logic        g, rv, e;
        logic [31:0] rd;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s[0], g, rv, e, rd);
            tests++;
            if ({g, rv, e} !== 3'b000) begin
                fails++;
                $display("FAIL reset_pulses dut%0d: got %b expected 000", s * 3, {g, rv, e});
            end
            tests++;
            if (rd !== 32'h0) begin
                fails++;
                $display("FAIL reset_rdata dut%0d: got %h expected 00000000", s * 3, rd);
            end
        end
        tests++;
        if (st0 !== 2'd0 || st3 !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d/%0d expected 0/0", st0, st3);
        end
    endtask

    task automatic test_basic();
        logic [31:0] got;
        access(1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 1, "basic_write", got);
        access(1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1, "basic_read", got);
        tests++;
        if (got !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL basic_value: got %h expected deadbeef", got);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] got;
        access(1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h11223344, 4'b0101, 1'b0, 1, "lane_write", got);
        access(1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 1, "lane_read", got);
        tests++;
        if (got !== 32'hDE22BE44) begin
            fails++;
            $display("FAIL lane_value: got %h expected de22be44", got);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] got;
        logic        saw;
        access(1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 32'hA5A55A5A, 4'hF, 1'b0, 4, "ws_write", got);
        access(1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4, "ws_read", got);
        // Abandoned write: req dropped during the wait window.
        saw = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 32'hFFFFFFFF, 4'hF);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (b3.grnt) saw = 1'b1;
            if (c == 1) begin
                @(posedge clk); #1;
                drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
            end
        end
        tests++;
        if (saw !== 1'b0) begin
            fails++;
            $display("FAIL ws_abandon_grant: got %b expected 0", saw);
        end
        tests++;
        if (st3 !== 2'd0) begin
            fails++;
            $display("FAIL ws_abandon_state: got %0d expected 0", st3);
        end
        access(1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4, "ws_after_abandon", got);
        tests++;
        if (got !== 32'hA5A55A5A) begin
            fails++;
            $display("FAIL ws_abandon_value: got %h expected a5a55a5a", got);
        end
    endtask

    task automatic test_errors();
        logic [31:0] got;
        access(1'b0, 1'b0, 32'h12, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1, "err_misaligned", got);
        access(1'b0, 1'b0, 32'd4096, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1, "err_range", got);
        access(1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h0, 4'hF, 1'b1, 1, "err_both", got);
        access(1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 4'hF, 1'b1, 1, "err_neither", got);
        access(1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'hFFFFFFFF, 4'h0, 1'b1, 1, "err_no_lanes", got);
        access(1'b0, 1'b0, 32'h11, 1'b0, 1'b1, 32'h0, 4'hF, 1'b1, 1, "err_wr_misaligned", got);
        access(1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1, "err_readback", got);
        tests++;
        if (got !== 32'hDE22BE44) begin
            fails++;
            $display("FAIL err_untouched: got %h expected de22be44", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        access(1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 32'h0BADCAFE, 4'hF, 1'b0, 1, "b2b_write", got);
        // Next request raised during the response cycle: ignored there, taken next IDLE.
        access(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 2, "b2b_read", got);
        tests++;
        if (got !== 32'h0BADCAFE) begin
            fails++;
            $display("FAIL b2b_value: got %h expected 0badcafe", got);
        end
        access(1'b1, 1'b0, 32'h44, 1'b0, 1'b1, 32'h600DF00D, 4'hF, 1'b0, 4, "b2b_ws_write", got);
        access(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 5, "b2b_ws_read", got);
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 1'b0, 32'h100 + 32'(i * 4), 1'b0, 1'b1, $urandom, 4'hF, 1'b0, 1,
                   "rand_fill", got);
        end
        for (int i = 0; i < 12; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 7) * 4);
            access(1'b0, 1'b0, a, 1'b0, 1'b1, $urandom, 4'($urandom_range(1, 15)), 1'b0, 1,
                   "rand_write", got);
        end
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 1'b0, 32'h100 + 32'(i * 4), 1'b1, 1'b0, 32'h0,
                   4'($urandom_range(0, 15)), 1'b0, 1, "rand_read", got);
        end
    endtask

    task automatic test_reset_in_grant();
        logic [31:0] got;
        access(1'b0, 1'b0, 32'h20, 1'b0, 1'b1, 32'h12345678, 4'hF, 1'b0, 1, "rg_prewrite", got);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (b0.grnt !== 1'b1) begin
            fails++;
            $display("FAIL rg_grant: got %b expected 1", b0.grnt);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        tests++;
        if ({b0.grnt, b0.rvalid, b0.err} !== 3'b000 || st0 !== 2'd0) begin
            fails++;
            $display("FAIL rg_no_response: got pulses %b state %0d expected 000 state 0",
                     {b0.grnt, b0.rvalid, b0.err}, st0);
        end
        access(1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1, "rg_read", got);
        tests++;
        if (got !== 32'h12345678) begin
            fails++;
            $display("FAIL rg_value: got %h expected 12345678", got);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic();
        test_lanes();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_in_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
